// File: rtl/disp_pkg.sv
// Shared display definitions: FSM encoding, blank pattern and digit byte layout
// used by the share controller and the scanning display controller.
package disp_pkg;

    localparam int unsigned DIGIT_W    = 8;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SSEG_W     = DIGIT_W * NUM_DIGITS;

    // Byte lanes of a 32-bit pattern; digit3 sits in the top byte.
    localparam int unsigned DIG0_LSB = 0 * DIGIT_W;
    localparam int unsigned DIG1_LSB = 1 * DIGIT_W;
    localparam int unsigned DIG2_LSB = 2 * DIGIT_W;
    localparam int unsigned DIG3_LSB = 3 * DIGIT_W;

    // Segments are active-low, so all ones turns every segment off.
    localparam logic [SSEG_W-1:0] SSEG_BLANK = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHOW  = 2'b01,
        ST_BLANK = 2'b10
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// searching upward with wrap, so the entry at ptr has lowest priority.
module rr_pick #(
    parameter  int unsigned NREQ = 3,
    localparam int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            found,
    output logic [PW-1:0]   idx,
    output logic [NREQ-1:0] onehot
);

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!found && req[PW'((32'(ptr) + k) % NREQ)]) begin
                found = 1'b1;
                idx   = PW'((32'(ptr) + k) % NREQ);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            onehot[i] = found && (idx == PW'(i));
        end
    end

endmodule

// File: rtl/sseg_share_ctrl.sv
// Time-shares the seven-segment scanner between NREQ requesters: round-robin
// grant, minimum dwell per owner, optional blank gap between owners.
module sseg_share_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned DWELL_CYC = 12_000_000,
    parameter int unsigned BLANK_CYC = 4000,
    parameter int unsigned CW        = 24
) (
    input  logic                   clk_s,
    input  logic                   rst_s,
    input  logic [NREQ-1:0]        req_s,
    input  logic [SSEG_W*NREQ-1:0] pat_s,
    output logic [NREQ-1:0]        gnt_s,
    output logic [NREQ-1:0]        done_s,
    output logic [SSEG_W-1:0]      sseg_s,
    output logic                   busy_s,
    output logic [2:0]             owner_s
);

    localparam int unsigned PW = $clog2(NREQ);

    // Build-time parameter sanity.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("sseg_share_ctrl: NREQ must be 2..8");
    end
    if (DWELL_CYC < 1) begin : g_bad_dwell_min
        $error("sseg_share_ctrl: DWELL_CYC must be >= 1");
    end
    if (64'(DWELL_CYC) > ((64'(1) << CW) - 64'(1))) begin : g_bad_dwell_w
        $error("sseg_share_ctrl: DWELL_CYC does not fit in CW bits");
    end
    if (64'(BLANK_CYC) > ((64'(1) << CW) - 64'(1))) begin : g_bad_blank_w
        $error("sseg_share_ctrl: BLANK_CYC does not fit in CW bits");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [SSEG_W-1:0] sseg_q, sseg_d;
    logic              busy_q, busy_d;

    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [NREQ-1:0]   pick_onehot;
    logic [SSEG_W-1:0] pat_own, pat_new;
    logic              own_req, other_req, cnt_zero;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req_s),
        .ptr    (ptr_q),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Pattern slices of the current owner and of the candidate being granted.
    always_comb begin
        pat_own = SSEG_BLANK;
        pat_new = SSEG_BLANK;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == PW'(i)) pat_own = pat_s[SSEG_W*i +: SSEG_W];
            if (pick_idx == PW'(i)) pat_new = pat_s[SSEG_W*i +: SSEG_W];
        end
    end

    assign own_req   = |(req_s & gnt_q);
    assign other_req = |(req_s & ~gnt_q);
    assign cnt_zero  = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        sseg_d  = SSEG_BLANK;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                gnt_d  = '0;
                if (pick_found) begin
                    state_d = ST_SHOW;
                    gnt_d   = pick_onehot;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = CW'(DWELL_CYC - 1);
                    sseg_d  = pat_new;
                    busy_d  = 1'b1;
                end
            end
            ST_SHOW: begin
                // A dropped owner leaves at once; otherwise yield only after dwell.
                if (!own_req || (cnt_zero && other_req)) begin
                    gnt_d  = '0;
                    done_d = gnt_q;
                    if (BLANK_CYC > 0) begin
                        state_d = ST_BLANK;
                        cnt_d   = CW'(BLANK_CYC - 1);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    sseg_d = pat_own;
                    cnt_d  = cnt_zero ? cnt_q : cnt_q - CW'(1);
                end
            end
            ST_BLANK: begin
                gnt_d = '0;
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_s or negedge rst_s) begin
        if (!rst_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            sseg_q  <= SSEG_BLANK;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            sseg_q  <= sseg_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_s   = gnt_q;
    assign done_s  = done_q;
    assign sseg_s  = sseg_q;
    assign busy_s  = busy_q;
    assign owner_s = 3'(owner_q);

endmodule
